trap_sequencer: RTL
===================

// Module: trap_sequencer
// PURPOSE
//  Machine-mode trap/interrupt/MRET controller at the commit boundary after the memory stage.
//  Serialises CSR side effects (MEPC, MCAUSE, MTVAL, MSTATUS) over the single CSR write port.
//  Stalls/flushes the pipeline while doing so, then issues one fetch redirect.
// PARAMETERS
//  INT_SYNC_STAGES  2   synchroniser depth for the external interrupt line (>=2)
// PORTS
//  clock            in   1    core clock
//  reset            in   1    asynchronous, active-low reset
//  interrupt        in   1    external interrupt request, asynchronous level
//  commitValid      in   1    valid instruction at commit boundary
//  commitTrapType   in   trapType_  trap raised by that instruction (NONE = none)
//  commitPC         in   32   PC of committing instruction
//  commitFaultAddr  in   32   faulting address / tval source
//  commitMRET       in   1    committing instruction is MRET
//  csrMstatus       in   32   current MSTATUS (MIE bit3, MPIE bit7)
//  csrMie           in   32   current MIE (MEIE bit11)
//  csrMtvec         in   32   current MTVEC
//  csrMepc          in   32   current MEPC
//  commitKill       out  1    suppress retirement/writeback of committing instruction
//  csrWriteEnable   out  1    CSR write strobe
//  csrWriteAddress  out  destinationCSR_  CSR written this cycle
//  csrWriteData     out  32   CSR write data
//  stallPipeline    out  1    hold all stages
//  flushPipeline    out  1    one-cycle flush of all stages
//  redirectValid    out  1    one-cycle fetch redirect strobe
//  redirectPC       out  32   redirect target
//  interruptPending out  1    synchronised interrupt level (MIP.MEIP source)
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; all outputs 0; csrWriteAddress=MSTATUS; latches and synchroniser cleared.
//  Event select in IDLE, cycle N (priority order, only when commitValid):
//   1 commitTrapType!=NONE -> TRAP; cause=trapCause(commitTrapType), tval=commitFaultAddr, epc=commitPC
//   2 interruptPending && MSTATUS.MIE && MIE.MEIE -> INTR; cause=32'h8000_000B, tval=0, epc=commitPC
//   3 commitMRET -> MRET; target=csrMepc
//  commitKill: combinational, high in cycle N for TRAP and INTR only.
//  Cycle N latches cause/tval/epc/old MIE/MPIE/target. No outputs other than commitKill change in N.
//  TRAP/INTR states: WR_MEPC(N+1) WR_MCAUSE(N+2) WR_MTVAL(N+3) WR_MSTATUS(N+4) REDIRECT(N+5) -> IDLE.
//  MRET states: MRET_MSTATUS(N+1) REDIRECT(N+2) -> IDLE.
//  WR_* / MRET_MSTATUS: csrWriteEnable=1, one CSR per cycle.
//  Trap MSTATUS data: MPP=2'b11, MPIE=oldMIE, MIE=0 (0x1880 if MIE was 1, else 0x1800).
//  MRET MSTATUS data: MPP=2'b11, MIE=oldMPIE, MPIE=1 (0x1888 or 0x1880).
//  MEPC data epc&~3; MCAUSE/MTVAL data as latched.
//  flushPipeline=1 only in first post-event state (N+1). stallPipeline=1 whenever state!=IDLE.
//  REDIRECT: redirectValid=1 for exactly one cycle.
//   TRAP/INTR: redirectPC={csrMtvec[31:2],2'b00}. MRET: latched target.
//  Outside IDLE: commitValid, commitMRET and the interrupt are ignored; interrupt stays pending, re-evaluated in IDLE.
//  Reset asserted mid-sequence: immediate abort to IDLE; no partial redirect; already-written CSRs not reverted.
//  interruptPending: INT_SYNC_STAGES-flop synchroniser on interrupt, registered output.
//  Latency: interrupt edge to earliest take = INT_SYNC_STAGES cycles.
// CONFIGURATION
//  VECTORED_INT_EN defined: INTR with csrMtvec[1:0]==2'b01 -> redirectPC = base + 4*cause[30:0].
//   TRAP always uses base. csrMtvec[1:0]==2'b00 always uses base.
//  Undefined: mtvec mode bits ignored; all redirects go to base.
// STRUCTURE
//  pack: trapSeqState_ enum; MCAUSE_MEI constant; trapCause(trapType_) function;
//   MSTATUS_MIE/MPIE/MPP bit-position constants.
//  Sub-module: interrupt_synchronizer (parameterised flop chain, async active-low clear).
// TESTING
//  1 Illegal-instr trap, PC=0x100, fault=0x0BAD, mtvec=0x200, MIE=1
//    -> writes MEPC=0x100, MCAUSE=2, MTVAL=0x0BAD, MSTATUS=0x1880; redirect 0x200 at N+5.
//  2 Interrupt held, MIE=1, MEIE=1, commitPC=0x400
//    -> commitKill at N; MCAUSE=0x8000000B, MTVAL=0; redirect 0x200.
//  3 MRET, csrMepc=0x404, MPIE=1 -> MSTATUS=0x1888 at N+1; redirect 0x404 at N+2; no flush at N+2.
//  4 Trap and interrupt same cycle -> trap taken.
//    Interrupt not retaken while MIE=0; taken after MRET restores MIE.
//  5 reset low during WR_MCAUSE -> all outputs 0 same cycle; no redirect; IDLE after release.
//  6 VECTORED_INT_EN, mtvec=0x201, interrupt -> redirect 0x22C. Undefined -> 0x200. Trap -> 0x200 both.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// trap_sequencer_pkg
// Shared types and constants for the machine-mode trap sequencer:
//   trapType_       trap kinds reported at the commit boundary
//   destinationCSR_ CSR addresses the sequencer can write
//   trapSeqState_   sequencer FSM states
//   MCAUSE_MEI      mcause value of a machine external interrupt
//   MSTATUS_* / MIE_MEIE bit positions
//   trapCause()     trap kind -> mcause exception code
//   mstatusImage()  MSTATUS write image with MPP forced to machine mode
// -----------------------------------------------------------------------------
package trap_sequencer_pkg;

    typedef enum logic [3:0] {
        TRAP_NONE             = 4'd0,
        TRAP_INSTR_MISALIGNED = 4'd1,
        TRAP_INSTR_ACCESS     = 4'd2,
        TRAP_ILLEGAL_INSTR    = 4'd3,
        TRAP_BREAKPOINT       = 4'd4,
        TRAP_LOAD_MISALIGNED  = 4'd5,
        TRAP_LOAD_ACCESS      = 4'd6,
        TRAP_STORE_MISALIGNED = 4'd7,
        TRAP_STORE_ACCESS     = 4'd8,
        TRAP_ECALL_M          = 4'd9
    } trapType_;

    typedef enum logic [11:0] {
        CSR_MSTATUS = 12'h300,
        CSR_MEPC    = 12'h341,
        CSR_MCAUSE  = 12'h342,
        CSR_MTVAL   = 12'h343
    } destinationCSR_;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_MEPC      = 3'd1,
        ST_WR_MCAUSE    = 3'd2,
        ST_WR_MTVAL     = 3'd3,
        ST_WR_MSTATUS   = 3'd4,
        ST_MRET_MSTATUS = 3'd5,
        ST_REDIRECT     = 3'd6
    } trapSeqState_;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MEIE       = 11;

    // Exception code written to MCAUSE for a synchronous trap.
    function automatic logic [31:0] trapCause(input trapType_ t);
        logic [31:0] code;
        case (t)
            TRAP_INSTR_MISALIGNED: code = 32'd0;
            TRAP_INSTR_ACCESS:     code = 32'd1;
            TRAP_ILLEGAL_INSTR:    code = 32'd2;
            TRAP_BREAKPOINT:       code = 32'd3;
            TRAP_LOAD_MISALIGNED:  code = 32'd4;
            TRAP_LOAD_ACCESS:      code = 32'd5;
            TRAP_STORE_MISALIGNED: code = 32'd6;
            TRAP_STORE_ACCESS:     code = 32'd7;
            TRAP_ECALL_M:          code = 32'd11;
            default:               code = 32'd0;
        endcase
        return code;
    endfunction

    // MSTATUS image: only MPP/MPIE/MIE are produced, MPP always machine mode.
    function automatic logic [31:0] mstatusImage(input logic mpie, input logic mie);
        logic [31:0] img;
        img = 32'd0;
        img[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        img[MSTATUS_MPIE] = mpie;
        img[MSTATUS_MIE]  = mie;
        return img;
    endfunction

endpackage

// File: rtl/trap_sequencer_interrupt_synchronizer.sv
// -----------------------------------------------------------------------------
// trap_sequencer_interrupt_synchronizer
// Flop-chain synchroniser for an asynchronous level, asynchronously cleared.
//   clock     in  sampling clock
//   reset     in  asynchronous active-low clear
//   async_in  in  asynchronous level
//   sync_out  out synchronised level (last flop of the chain)
// STAGES must be >= 2.
// -----------------------------------------------------------------------------
module trap_sequencer_interrupt_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the input one stage deeper every cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
    end

    // Chain flops with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
// Machine-mode trap / external interrupt / MRET controller at the commit
// boundary. On an event it kills the committing instruction (trap/interrupt),
// serialises MEPC, MCAUSE, MTVAL, MSTATUS writes (or the single MRET MSTATUS
// write) over one CSR write port while stalling the pipeline, flushes in the
// first post-event cycle, then issues one fetch redirect.
// Ports:
//   clock, reset (async active-low)
//   interrupt                                   async external interrupt level
//   commitValid/TrapType/PC/FaultAddr/MRET      committing instruction info
//   csrMstatus/csrMie/csrMtvec/csrMepc          current CSR values
//   commitKill                                  combinational retire suppress
//   csrWriteEnable/Address/Data                 CSR write port (registered)
//   stallPipeline/flushPipeline                 pipeline control (registered)
//   redirectValid/redirectPC                    fetch redirect (registered)
//   interruptPending                            synchronised interrupt level
// Configuration macro: VECTORED_INT_EN -- when defined, interrupts with
// mtvec mode 2'b01 redirect to base + 4*cause; otherwise always base.
// -----------------------------------------------------------------------------
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int INT_SYNC_STAGES = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           interrupt,
    input  logic           commitValid,
    input  trapType_       commitTrapType,
    input  logic [31:0]    commitPC,
    input  logic [31:0]    commitFaultAddr,
    input  logic           commitMRET,
    input  logic [31:0]    csrMstatus,
    input  logic [31:0]    csrMie,
    input  logic [31:0]    csrMtvec,
    input  logic [31:0]    csrMepc,
    output logic           commitKill,
    output logic           csrWriteEnable,
    output destinationCSR_ csrWriteAddress,
    output logic [31:0]    csrWriteData,
    output logic           stallPipeline,
    output logic           flushPipeline,
    output logic           redirectValid,
    output logic [31:0]    redirectPC,
    output logic           interruptPending
);

    trapSeqState_   state_q, state_d;
    logic [31:0]    cause_q, cause_d;
    logic [31:0]    tval_q, tval_d;
    logic [31:0]    epc_q, epc_d;
    logic [31:0]    target_q, target_d;
    logic           old_mie_q, old_mie_d;
    logic           old_mpie_q, old_mpie_d;
    logic           is_mret_q, is_mret_d;
    logic           is_intr_q, is_intr_d;

    logic           csr_we_q, csr_we_d;
    destinationCSR_ csr_addr_q, csr_addr_d;
    logic [31:0]    csr_data_q, csr_data_d;
    logic           stall_q, stall_d;
    logic           flush_q, flush_d;
    logic           redirect_valid_q, redirect_valid_d;
    logic [31:0]    redirect_pc_q, redirect_pc_d;

    logic           int_take_s;
    logic           commit_kill_s;
    logic [31:0]    mtvec_base_s;

    trap_sequencer_interrupt_synchronizer #(
        .STAGES (INT_SYNC_STAGES)
    ) u_int_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (interrupt),
        .sync_out (interruptPending)
    );

    assign int_take_s   = interruptPending && csrMstatus[MSTATUS_MIE] && csrMie[MIE_MEIE];
    assign mtvec_base_s = {csrMtvec[31:2], 2'b00};

    // Event selection, state sequencing and next-cycle output decode.
    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        tval_d           = tval_q;
        epc_d            = epc_q;
        target_d         = target_q;
        old_mie_d        = old_mie_q;
        old_mpie_d       = old_mpie_q;
        is_mret_d        = is_mret_q;
        is_intr_d        = is_intr_q;
        commit_kill_s    = 1'b0;
        csr_we_d         = 1'b0;
        csr_addr_d       = CSR_MSTATUS;
        csr_data_d       = 32'd0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (commitValid && (commitTrapType != TRAP_NONE)) begin
                    commit_kill_s = 1'b1;
                    cause_d       = trapCause(commitTrapType);
                    tval_d        = commitFaultAddr;
                    epc_d         = commitPC;
                    old_mie_d     = csrMstatus[MSTATUS_MIE];
                    old_mpie_d    = csrMstatus[MSTATUS_MPIE];
                    is_mret_d     = 1'b0;
                    is_intr_d     = 1'b0;
                    state_d       = ST_WR_MEPC;
                end else if (commitValid && int_take_s) begin
                    commit_kill_s = 1'b1;
                    cause_d       = MCAUSE_MEI;
                    tval_d        = 32'd0;
                    epc_d         = commitPC;
                    old_mie_d     = csrMstatus[MSTATUS_MIE];
                    old_mpie_d    = csrMstatus[MSTATUS_MPIE];
                    is_mret_d     = 1'b0;
                    is_intr_d     = 1'b1;
                    state_d       = ST_WR_MEPC;
                end else if (commitValid && commitMRET) begin
                    target_d   = csrMepc;
                    old_mie_d  = csrMstatus[MSTATUS_MIE];
                    old_mpie_d = csrMstatus[MSTATUS_MPIE];
                    is_mret_d  = 1'b1;
                    is_intr_d  = 1'b0;
                    state_d    = ST_MRET_MSTATUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_MEPC:      state_d = ST_WR_MCAUSE;
            ST_WR_MCAUSE:    state_d = ST_WR_MTVAL;
            ST_WR_MTVAL:     state_d = ST_WR_MSTATUS;
            ST_WR_MSTATUS:   state_d = ST_REDIRECT;
            ST_MRET_MSTATUS: state_d = ST_REDIRECT;
            ST_REDIRECT:     state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they belong to.
        case (state_d)
            ST_WR_MEPC: begin
                csr_we_d   = 1'b1;
                csr_addr_d = CSR_MEPC;
                csr_data_d = epc_d & ~32'd3;
            end
            ST_WR_MCAUSE: begin
                csr_we_d   = 1'b1;
                csr_addr_d = CSR_MCAUSE;
                csr_data_d = cause_d;
            end
            ST_WR_MTVAL: begin
                csr_we_d   = 1'b1;
                csr_addr_d = CSR_MTVAL;
                csr_data_d = tval_d;
            end
            ST_WR_MSTATUS: begin
                csr_we_d   = 1'b1;
                csr_addr_d = CSR_MSTATUS;
                csr_data_d = mstatusImage(old_mie_d, 1'b0);
            end
            ST_MRET_MSTATUS: begin
                csr_we_d   = 1'b1;
                csr_addr_d = CSR_MSTATUS;
                csr_data_d = mstatusImage(1'b1, old_mpie_d);
            end
            ST_REDIRECT: begin
                redirect_valid_d = 1'b1;
                if (is_mret_d) begin
                    redirect_pc_d = target_d;
                end else begin
`ifdef VECTORED_INT_EN
                    if (is_intr_d && (csrMtvec[1:0] == 2'b01)) begin
                        redirect_pc_d = mtvec_base_s + {cause_d[29:0], 2'b00};
                    end else begin
                        redirect_pc_d = mtvec_base_s;
                    end
`else
                    redirect_pc_d = mtvec_base_s;
`endif
                end
            end
            default: begin
                csr_we_d = 1'b0;
            end
        endcase

        stall_d = (state_d != ST_IDLE);
        flush_d = (state_q == ST_IDLE) && (state_d != ST_IDLE);
    end

    // State, event latches and registered outputs; reset aborts any sequence.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            cause_q          <= 32'd0;
            tval_q           <= 32'd0;
            epc_q            <= 32'd0;
            target_q         <= 32'd0;
            old_mie_q        <= 1'b0;
            old_mpie_q       <= 1'b0;
            is_mret_q        <= 1'b0;
            is_intr_q        <= 1'b0;
            csr_we_q         <= 1'b0;
            csr_addr_q       <= CSR_MSTATUS;
            csr_data_q       <= 32'd0;
            stall_q          <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            cause_q          <= cause_d;
            tval_q           <= tval_d;
            epc_q            <= epc_d;
            target_q         <= target_d;
            old_mie_q        <= old_mie_d;
            old_mpie_q       <= old_mpie_d;
            is_mret_q        <= is_mret_d;
            is_intr_q        <= is_intr_d;
            csr_we_q         <= csr_we_d;
            csr_addr_q       <= csr_addr_d;
            csr_data_q       <= csr_data_d;
            stall_q          <= stall_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign commitKill      = commit_kill_s;
    assign csrWriteEnable  = csr_we_q;
    assign csrWriteAddress = csr_addr_q;
    assign csrWriteData    = csr_data_q;
    assign stallPipeline   = stall_q;
    assign flushPipeline   = flush_q;
    assign redirectValid   = redirect_valid_q;
    assign redirectPC      = redirect_pc_q;

    // CSR fields this block never looks at.
    logic unused_ok;
    assign unused_ok = &{1'b0, csrMstatus[31:8], csrMstatus[6:4], csrMstatus[2:0],
                         csrMie[31:12], csrMie[10:0], csrMtvec[1:0], is_intr_q};

endmodule
